chien_search_parallel: RTL
==========================

CHIEN_SEARCH_PARALLEL -- requirements
Module: chien_search_parallel

Interface
REQ-001 SHALL have parameter M, default 4, meaning GF(2^M) symbol width; codeword length N = 2^M-1.
REQ-002 SHALL have parameter T, default 3, meaning correctable errors; locator has T+1 coefficients; T < 2^M-1.
REQ-003 SHALL have parameter PRIM_POLY, width M+1, default 5'b10011 (x^4+x+1), meaning field primitive polynomial.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request to load a locator polynomial.
REQ-007 SHALL have port cNin  input  M*(T+1)  locator coefficients; coefficient i at bits [i*M +: M], standard basis.
REQ-008 SHALL have port ready  input  1  downstream may accept an err beat this cycle.
REQ-009 SHALL have port busy  output  1  search in progress.
REQ-010 SHALL have port err_valid  output  1  err/err_pos valid this cycle.
REQ-011 SHALL have port err  output  1  bit at err_pos is in error.
REQ-012 SHALL have port err_pos  output  M  codeword bit position, N-1 down to 0.
REQ-013 SHALL have port done  output  1  one-cycle pulse after the last beat.
REQ-014 SHALL have port err_count  output  M  roots found in the current/last search.
REQ-015 SHALL have port fail  output  1  uncorrectable indication, valid with done and held until next start.

Function
REQ-016 SHALL implement states IDLE and SEARCH; busy = (state==SEARCH), registered.
REQ-017 In IDLE, start=1 at an edge SHALL load r_i <= c_i*alpha^i for i=0..T, step counter k <= 1, err_count <= 0, fail <= 0, deg <= highest i with c_i != 0 (0 if none), state <= SEARCH.
REQ-018 start while busy=1 SHALL be ignored; loaded polynomial is unaffected.
REQ-019 In SEARCH with ready=1, each edge SHALL register err <= (XOR of all r_i == 0), err_pos <= N-k, err_valid <= 1, r_i <= r_i*alpha^i, k <= k+1, err_count <= err_count + err-term.
REQ-020 In SEARCH with ready=0, all state SHALL hold and err_valid SHALL be 0 next cycle; no position skipped or repeated.
REQ-021 err_valid SHALL be 0 whenever no step was taken at the preceding edge.
REQ-022 The step with k=N (err_pos=0) SHALL be last; at that edge state <= IDLE; done SHALL be 1 in the following cycle only.
REQ-023 First err_valid SHALL occur one cycle after the load edge; with ready held 1, exactly N beats, done the cycle after the last beat (N+2 cycles start to done inclusive).
REQ-024 fail, registered with done, SHALL be 1 iff final err_count != deg, or all coefficients are zero.
REQ-025 Multiplication by alpha^i SHALL be constant GF(2^M) reduction by PRIM_POLY, combinational, no multi-cycle paths.
REQ-026 err_count SHALL not wrap (max N fits in M bits).
REQ-027 start accepted in the same cycle done is asserted SHALL begin a new search normally.

Reset
REQ-028 reset=1 SHALL asynchronously force state IDLE, busy=0, err_valid=0, err=0, err_pos=0, done=0, err_count=0, fail=0, r_i=0, k=0.
REQ-029 reset asserted mid-search SHALL abort the search without a done pulse; first edge after release SHALL honour start.

Verification (M=4, T=3, PRIM_POLY=5'b10011)
REQ-030 Single error: cNin c0=4'h1,c1=4'h6 (alpha^5),c2=c3=0, ready=1 -> 15 beats, err=1 only at err_pos=5, done with err_count=1, fail=0.
REQ-031 Double error: c0=4'h1,c1=4'hE,c2=4'hE,c3=0 -> err=1 at err_pos 9 and 2 only, err_count=2, fail=0.
REQ-032 Repeated root: c0=4'h1,c1=0,c2=4'h1,c3=0 -> err=1 only at err_pos=0, err_count=1, deg=2, fail=1.
REQ-033 Backpressure: REQ-030 stimulus, ready=0 for 3 cycles after 4th beat -> err_valid low 3 cycles, beats resume at err_pos=10, sequence and result unchanged.
REQ-034 Reset mid-search: reset 1 cycle after 6th beat -> all outputs 0 immediately, no done; restart with REQ-031 stimulus yields REQ-031 result.
REQ-035 No errors: c0=4'h1, others 0 -> 15 beats all err=0, err_count=0, fail=0; start pulsed during search is ignored.

Source files
------------

// File: rtl/chien_search_parallel.sv
// Chien search over GF(2^M): evaluates the error locator at alpha^1..alpha^N, one
// position per accepted beat, and reports root positions plus a final consistency flag.
module chien_lane #(
    parameter int                 M         = 4,
    parameter logic [M:0]         PRIM_POLY = 5'b10011,
    parameter int                 I         = 0
) (
    input  logic [M-1:0] coef,
    input  logic [M-1:0] r,
    output logic [M-1:0] load_val,
    output logic [M-1:0] step_val
);
    // Constant multiply by alpha^I: I repeated xtime steps, folds into XOR trees.
    function automatic logic [M-1:0] mul_apow(input logic [M-1:0] v);
        logic [M-1:0] acc;
        acc = v;
        for (int j = 0; j < I; j++)
            acc = {acc[M-2:0], 1'b0} ^ (acc[M-1] ? PRIM_POLY[M-1:0] : '0);
        return acc;
    endfunction

    assign load_val = mul_apow(coef);
    assign step_val = mul_apow(r);
endmodule

module chien_search_parallel #(
    parameter int         M         = 4,
    parameter int         T         = 3,
    parameter logic [M:0] PRIM_POLY = 5'b10011
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [M*(T+1)-1:0] cNin,
    input  logic             ready,
    output logic             busy,
    output logic             err_valid,
    output logic             err,
    output logic [M-1:0]     err_pos,
    output logic             done,
    output logic [M-1:0]     err_count,
    output logic             fail
);
    localparam logic [M-1:0] N = '1;

    typedef enum logic {IDLE, SEARCH} state_t;
    state_t state;

    logic [T:0][M-1:0] c_in, r, r_load, r_step;
    logic [M-1:0]      k, deg, deg_c, cnt_next;
    logic              all_zero, hit;

    assign c_in = cNin;

    for (genvar i = 0; i <= T; i++) begin : g_lane
        chien_lane #(.M(M), .PRIM_POLY(PRIM_POLY), .I(i)) u_lane (
            .coef    (c_in[i]),
            .r       (r[i]),
            .load_val(r_load[i]),
            .step_val(r_step[i])
        );
    end

    // Sum of the lane terms is the locator evaluated at alpha^k.
    always_comb begin
        logic [M-1:0] s;
        s = '0;
        for (int i = 0; i <= T; i++) s = s ^ r[i];
        hit = (s == '0);
    end

    always_comb begin
        deg_c = '0;
        for (int i = 0; i <= T; i++)
            if (c_in[i] != '0) deg_c = M'(i);
    end

    assign cnt_next = err_count + {{(M-1){1'b0}}, hit};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            err_valid <= 1'b0;
            err       <= 1'b0;
            err_pos   <= '0;
            done      <= 1'b0;
            err_count <= '0;
            fail      <= 1'b0;
            r         <= '0;
            k         <= '0;
            deg       <= '0;
            all_zero  <= 1'b0;
        end else begin
            err_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    r         <= r_load;
                    k         <= {{(M-1){1'b0}}, 1'b1};
                    err_count <= '0;
                    fail      <= 1'b0;
                    deg       <= deg_c;
                    all_zero  <= (cNin == '0);
                    state     <= SEARCH;
                    busy      <= 1'b1;
                end
                SEARCH: if (ready) begin
                    err       <= hit;
                    err_pos   <= N - k;
                    err_valid <= 1'b1;
                    r         <= r_step;
                    k         <= k + 1'b1;
                    err_count <= cnt_next;
                    if (k == N) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        fail  <= (cnt_next != deg) || all_zero;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
